// File: rtl/sensor_sample_fifo.sv
// Packs four capture-stage channel bytes into 32-bit words and buffers them in a
// DEPTH-entry FIFO drained by a valid/ready port, with occupancy/irq/overflow status.
module sensor_sample_fifo #(
   parameter int DEPTH  = 512,
   parameter int THRESH = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          smp_vld,
   input  logic [7:0]    smp_b0,
   input  logic [7:0]    smp_b1,
   input  logic [7:0]    smp_b2,
   input  logic [7:0]    smp_b3,
   input  logic          clr,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [31:0]   rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          irq,
   output logic          ovf,
   output logic [15:0]   drop_cnt
);

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   THRESH_C = (AW+1)'(THRESH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

   logic [31:0]   mem_r [0:DEPTH-1];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          ovf_r;
   logic [15:0]   drop_cnt_r;

   logic [31:0]   word_s;
   logic          full_s;
   logic          empty_s;
   logic          wr_s;
   logic          rd_s;
   logic          drop_s;
   logic          flush_s;

   // Transfer decode; a read frees a slot so a full FIFO still accepts a same-cycle sample.
   always_comb begin
      word_s  = {smp_b3, smp_b2, smp_b1, smp_b0};
      full_s  = (count_r == DEPTH_C);
      empty_s = (count_r == {(AW+1){1'b0}});
      flush_s = rst | clr;
      rd_s    = !empty_s & rd_ready;
      wr_s    = smp_vld & (!full_s | rd_s);
      drop_s  = smp_vld & full_s & !rd_s;
   end

   // Sample storage; contents survive a flush.
   always_ff @(posedge clk) begin
      if (wr_s && !flush_s) begin
         mem_r[wptr_r] <= word_s;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (flush_s) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW+1){1'b0}};
      end else begin
         if (wr_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (rd_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         if (wr_s && !rd_s) begin
            count_r <= count_r + CNT_ONE;
         end else if (rd_s && !wr_s) begin
            count_r <= count_r - CNT_ONE;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk) begin
      if (flush_s) begin
         ovf_r      <= 1'b0;
         drop_cnt_r <= 16'h0000;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
         if (drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
         end
      end
   end

   assign rd_valid = !empty_s;
   assign rd_data  = empty_s ? 32'h0000_0000 : mem_r[rptr_r];
   assign count    = count_r;
   assign full     = full_s;
   assign empty    = empty_s;
   assign irq      = (count_r >= THRESH_C);
   assign ovf      = ovf_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_sensor_sample_fifo.sv
// Randomised and directed bench for sensor_sample_fifo (DEPTH=8, THRESH=4) against a
// queue-based reference model compared every cycle, plus literal spot checks.
module tb_sensor_sample_fifo;

   localparam int DEPTH  = 8;
   localparam int THRESH = 4;

   logic        clk = 1'b0;
   logic        rst, smp_vld, clr, rd_ready;
   logic [7:0]  smp_b0, smp_b1, smp_b2, smp_b3;
   logic        rd_valid, full, empty, irq, ovf;
   logic [31:0] rd_data;
   logic [3:0]  count;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [31:0] mq[$];
   bit          m_ovf;
   int          m_drop;

   sensor_sample_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk(clk), .rst(rst), .smp_vld(smp_vld),
      .smp_b0(smp_b0), .smp_b1(smp_b1), .smp_b2(smp_b2), .smp_b3(smp_b3),
      .clr(clr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty), .irq(irq), .ovf(ovf),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word queue plus overflow bookkeeping, updated on each edge.
   always @(posedge clk) begin
      bit was_full, pop;
      if (rst || clr) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() != 0) && rd_ready;
         if (pop) void'(mq.pop_front());
         if (smp_vld) begin
            if (!was_full || pop) begin
               mq.push_back({smp_b3, smp_b2, smp_b1, smp_b0});
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
         check("rd_data",  rd_data, (mq.size() != 0) ? mq[0] : 32'h0);
         check("count",    32'(count), 32'(mq.size()));
         check("full",     32'(full), 32'(mq.size() == DEPTH));
         check("empty",    32'(empty), 32'(mq.size() == 0));
         check("irq",      32'(irq), 32'(mq.size() >= THRESH));
         check("ovf",      32'(ovf), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b0, b1, b2, b3);
      smp_vld = 1'b1;
      smp_b0 = b0; smp_b1 = b1; smp_b2 = b2; smp_b3 = b3;
      step();
      smp_vld = 1'b0;
   endtask

   function automatic logic [31:0] fill_word(input int i);
      logic [7:0] b;
      b = 8'(4 * i);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   initial begin
      logic [31:0] w;
      rst = 1'b1; clr = 1'b0; smp_vld = 1'b0; rd_ready = 1'b0;
      smp_b0 = 8'h00; smp_b1 = 8'h00; smp_b2 = 8'h00; smp_b3 = 8'h00;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_count", 32'(count), 32'd0);

      // Basic packing
      strobe(8'h11, 8'h22, 8'h33, 8'h44);
      check("pack_data",  rd_data, 32'h4433_2211);
      check("pack_valid", 32'(rd_valid), 32'd1);
      check("pack_count", 32'(count), 32'd1);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      check("pop_empty", 32'(empty), 32'd1);
      check("pop_data",  rd_data, 32'h0);

      // Fill to threshold and full
      for (int i = 0; i < DEPTH; i++) begin
         w = fill_word(i);
         strobe(w[7:0], w[15:8], w[23:16], w[31:24]);
         if (i == 2) check("irq_below", 32'(irq), 32'd0);
         if (i == 3) check("irq_at",    32'(irq), 32'd1);
      end
      check("full_at_8", 32'(full), 32'd1);

      // Overflow
      for (int i = 0; i < 3; i++) strobe(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_flag",  32'(ovf), 32'd1);
      check("ovf_drops", 32'(drop_cnt), 32'd3);
      check("ovf_head",  rd_data, fill_word(0));
      rd_ready = 1'b1;
      strobe(8'h01, 8'h02, 8'h03, 8'h04);
      check("full_rd_count", 32'(count), 32'd8);
      check("full_rd_drops", 32'(drop_cnt), 32'd3);
      check("full_rd_head",  rd_data, fill_word(1));

      // Drain everything; order checked by the model
      repeat (DEPTH) step();
      rd_ready = 1'b0;
      check("drain_empty", 32'(empty), 32'd1);

      // Simultaneous events on empty FIFO, then clr with a strobe
      rd_ready = 1'b1;
      strobe(8'h5A, 8'h6B, 8'h7C, 8'h8D);
      rd_ready = 1'b0;
      check("empty_wr_rd", 32'(count), 32'd1);
      clr = 1'b1;
      strobe(8'h99, 8'h99, 8'h99, 8'h99);
      clr = 1'b0;
      check("clr_count", 32'(count), 32'd0);
      check("clr_drops", 32'(drop_cnt), 32'd0);

      // Randomised traffic across pointer wrap
      for (int c = 0; c < 400; c++) begin
         smp_vld  = ($urandom_range(0, 9) < 6);
         rd_ready = ($urandom_range(0, 9) < 5);
         clr      = ($urandom_range(0, 59) == 0);
         smp_b0 = 8'($urandom); smp_b1 = 8'($urandom);
         smp_b2 = 8'($urandom); smp_b3 = 8'($urandom);
         step();
      end
      smp_vld = 1'b0; rd_ready = 1'b0; clr = 1'b0;

      // Reset mid-operation at count 5 with ovf set
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         w = fill_word(i + 10);
         strobe(w[7:0], w[15:8], w[23:16], w[31:24]);
      end
      rd_ready = 1'b1; repeat (3) step(); rd_ready = 1'b0;
      check("pre_rst_count", 32'(count), 32'd5);
      check("pre_rst_ovf",   32'(ovf), 32'd1);
      rst = 1'b1;
      strobe(8'hEE, 8'hEE, 8'hEE, 8'hEE);
      rst = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_ovf",   32'(ovf), 32'd0);
      check("rst_drops", 32'(drop_cnt), 32'd0);
      check("rst_data",  rd_data, 32'h0);
      strobe(8'h10, 8'h20, 8'h30, 8'h40);
      check("post_rst_count", 32'(count), 32'd1);
      check("post_rst_data",  rd_data, 32'h4030_2010);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sensor_sample_fifo.md
# sensor_sample_fifo

Downstream consumer of the sensor capture stage. Each cycle the capture stage asserts its one-cycle ready strobe, this block packs the four 8-bit channel bytes into one 32-bit word and pushes it into a DEPTH-entry FIFO. The CPU/DMA side drains the FIFO through a valid/ready read port. The block provides occupancy, threshold interrupt, overflow and drop-count status.

## Interface
- DEPTH, 512: FIFO depth in 32-bit words; power of two, at least 4.
- THRESH, 256: irq asserts when count ≥ THRESH; legal range 1..DEPTH.
- AW, $clog2(DEPTH): derived pointer width; must not be overridden.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- smp_vld  in  1  sample strobe from the capture stage's ready output.
- smp_b0..smp_b3  in  8 each  channel bytes 0..3 from the capture stage.
- clr  in  1  synchronous flush: empties the FIFO and clears ovf and drop_cnt.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_data  out  32  head word {b3,b2,b1,b0}; 0 when empty.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- irq  out  1  level; count ≥ THRESH.
- ovf  out  1  sticky; set when a sample is dropped.
- drop_cnt  out  16  number of dropped samples; saturates at 16'hFFFF.

## Operation
- Packing: word = {smp_b3, smp_b2, smp_b1, smp_b0}. Byte 0 goes in bits [7:0].
- Storage:
  - Array mem[0:DEPTH-1] of 32 bits.
  - wptr and rptr are AW bits wide and wrap naturally from DEPTH-1 to 0.
  - count is a separate AW+1 counter.
- Write (wr):
  - wr = smp_vld & (!full | rd).
  - On wr: mem[wptr] ← word, then wptr+1.
- Read (rd):
  - rd = rd_valid & rd_ready.
  - On rd: rptr+1.
  - rd_data = mem[rptr] combinationally when !empty.
- Count update: count += wr − rd. When wr and rd occur together, count is unchanged.
- Full with simultaneous read: a sample arriving when full in the same cycle as a read is accepted, not dropped.
- Drop: smp_vld & full & !rd.
  - The sample is discarded and no FIFO state changes.
  - ovf ← 1.
  - drop_cnt ← drop_cnt+1, saturating.
- Empty with simultaneous sample: rd_valid=0, so no read occurs; the write proceeds.
- clr:
  - Next cycle: wptr = rptr = count = 0, ovf = 0, drop_cnt = 0.
  - clr overrides wr, rd and drop in the same cycle. A sample arriving during clr is lost and not counted as a drop.
  - Memory contents are not cleared.
- rst: same effect as clr. All outputs take their reset values in the cycle after rst is sampled, including when reset arrives mid-burst.
- Reset values of outputs:
  - rd_valid=0, rd_data=0, count=0, full=0, empty=1.
  - irq=0, ovf=0, drop_cnt=0.
- Sample rate: the capture stage cannot strobe on consecutive cycles, but the FIFO must accept back-to-back strobes every cycle regardless.

## Timing
- Write latency: a sample strobed in cycle N is visible at rd_data/rd_valid in cycle N+1 when the FIFO was empty before it.
- Read: combinational head. A pop in cycle N presents the next word in cycle N+1.
- Throughput: sustained 1 write + 1 read per cycle.
- Status registers: count, full, empty, irq, ovf and drop_cnt are registered or derived from registered count. All update on the edge that ends the wr/rd/drop cycle.
- irq tracks count with no additional delay; it has no hysteresis.

## Test plan
- Basic packing: reset, then one strobe with b0..b3 = 11,22,33,44 -> next cycle rd_valid=1, rd_data=32'h44332211, count=1. Then rd_ready=1 for one cycle -> empty=1, rd_data=0.
- Fill to threshold and full: DEPTH=8, THRESH=4, eight strobes with incrementing bytes -> irq rises on the edge where count becomes 4, full=1 at count 8. Draining all 8 returns words in order.
- Overflow: with full=1, three strobes with rd_ready=0 -> count stays 8, ovf=1, drop_cnt=3, head word unchanged. A strobe with rd_ready=1 when full -> accepted, count stays 8, drop_cnt stays 3.
- Pointer wrap: DEPTH=8, interleave 20 writes and reads with random rd_ready -> data order preserved across the wrap, count never exceeds 8 or goes below 0.
- Simultaneous events: empty FIFO with smp_vld=1 and rd_ready=1 -> write accepted, no pop, count=1. clr asserted together with smp_vld -> count=0, ovf=0, drop_cnt=0, no write.
- Reset mid-operation: at count=5 with ovf=1, assert rst for one cycle during a strobe -> all outputs at reset values next cycle. A subsequent strobe produces count=1 with the correct word.
